// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: accept -> DECODE -> EXEC -> MEM -> WB, one instruction at a time.
// Latency accept->retire: beq 2, R/addi 3, sw 3+w, lw 4+w cycles (w = memory wait cycles).
// Backpressure: instr_ready only in IDLE; MEM holds its strobe until mem_ready or timeout abort.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instruction,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             reg_read_en,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [4:0]       wr_addr,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_imm,
  output logic [1:0]       aluop,
  output logic             mem_read,
  output logic             mem_write,
  output logic             pc_write,
  output logic             branch_taken,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  state_t        state, state_nx;
  logic [31:0]   ir;
  logic [TW-1:0] wait_cnt;
  logic          zero_q;
  logic          timeout_q;
  logic          accept;
  logic          mem_abort;
  logic          is_r, is_lw, is_sw, is_beq, is_addi, legal;
  logic [4:0]    wr_sel;
  logic          unused_ir_bits;

  // Low IR bits (shamt/funct/immediate) are consumed by the datapath, not here.
  assign unused_ir_bits = ^ir[10:0];

  // Instruction class and destination register decoded from the latched IR.
  always_comb begin
    is_r    = (ir[31:26] == OP_R);
    is_lw   = (ir[31:26] == OP_LW);
    is_sw   = (ir[31:26] == OP_SW);
    is_beq  = (ir[31:26] == OP_BEQ);
    is_addi = (ir[31:26] == OP_ADDI);
    legal   = is_r | is_lw | is_sw | is_beq | is_addi;
    wr_sel  = is_r ? ir[15:11] : ir[20:16];
  end

  assign busy    = (state != S_IDLE);
  assign rs_addr = busy ? ir[25:21] : 5'd0;
  assign rt_addr = busy ? ir[20:16] : 5'd0;
  assign wr_addr = busy ? wr_sel    : 5'd0;

  // State register, IR, memory wait counter, branch flag and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      ir            <= '0;
      wait_cnt      <= '0;
      zero_q        <= 1'b0;
      timeout_q     <= 1'b0;
      retired_count <= '0;
    end else begin
      state     <= state_nx;
      // Registered so branch_taken never has a combinational path from alu_zero.
      zero_q    <= alu_zero;
      // Abort is flagged in the cycle after the strobe drops, back in IDLE.
      timeout_q <= mem_abort;
      if (accept) ir <= instruction;
      if (state == S_MEM) wait_cnt <= wait_cnt + TW'(1);
      else                wait_cnt <= '0;
      if (pc_write) retired_count <= retired_count + CNT_W'(1);
    end
  end

  // Next-state and control outputs per state.
  always_comb begin
    state_nx     = state;
    instr_ready  = 1'b0;
    accept       = 1'b0;
    ir_write     = 1'b0;
    reg_read_en  = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_imm  = 1'b0;
    aluop        = 2'b00;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    pc_write     = 1'b0;
    branch_taken = 1'b0;
    illegal      = timeout_q;
    mem_abort    = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept   = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        ir_write    = 1'b1;
        reg_read_en = 1'b1;
        if (legal) begin
          state_nx = S_EXEC;
        end else begin
          illegal  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_EXEC: begin
        alu_src_imm = is_lw | is_sw | is_addi;
        aluop       = is_beq ? 2'b01 : (is_r ? 2'b10 : 2'b00);
        if (is_beq) begin
          pc_write     = 1'b1;
          branch_taken = zero_q;
          state_nx     = S_IDLE;
        end else if (is_lw || is_sw) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        alu_src_imm = 1'b1;
        mem_read    = is_lw;
        mem_write   = is_sw;
        if (mem_ready) begin
          if (is_lw) begin
            state_nx = S_WB;
          end else begin
            // A store retires in the same cycle memory reports completion.
            pc_write = 1'b1;
            state_nx = S_IDLE;
          end
        end else if (wait_cnt == TW'(MEM_TIMEOUT - 1)) begin
          mem_abort = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      S_WB: begin
        reg_write  = (wr_sel != 5'd0);
        mem_to_reg = is_lw;
        pc_write   = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: expected per-instruction results are queued at issue
// and compared when the controller retires (pc_write) or aborts (illegal).
// Small counter width so retire-count wrap is reachable.
module tb_mips_multicycle_ctrl;

  localparam int TO = 15;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        alu_zero;
  logic        mem_ready;
  logic        ir_write, reg_read_en, reg_write, mem_to_reg, alu_src_imm;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic [1:0]  aluop;
  logic        mem_read, mem_write, pc_write, branch_taken, illegal, busy;
  logic [1:0]  retired_count;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .reg_read_en(reg_read_en), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .wr_addr(wr_addr), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_imm(alu_src_imm), .aluop(aluop), .mem_read(mem_read), .mem_write(mem_write),
    .pc_write(pc_write), .branch_taken(branch_taken), .illegal(illegal), .busy(busy),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ill;
    int         end_off;
    logic       bt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] aluop;
    logic       imm;
    int         mr;
    int         mw;
    int         rw;
    logic [4:0] wr;
    logic       wr_chk;
    logic       m2r;
  } exp_t;

  exp_t sb_q[$];
  exp_t ev;
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h @%0t", tag, obs, want, $time);
    end
  endtask

  // Reference behaviour for one instruction; w = memory wait cycles, negative = never ready.
  function automatic exp_t model(input logic [31:0] ins, input logic z, input int w);
    exp_t       e;
    logic [5:0] op;
    logic [4:0] rd;
    op = ins[31:26];
    rd = ins[15:11];
    e.ill = 1'b0; e.end_off = 0; e.bt = 1'b0; e.rs = ins[25:21]; e.rt = ins[20:16];
    e.aluop = 2'b00; e.imm = 1'b0; e.mr = 0; e.mw = 0; e.rw = 0; e.wr = 5'd0;
    e.wr_chk = 1'b0; e.m2r = 1'b0;
    case (op)
      6'h00: begin
        e.end_off = 3; e.aluop = 2'b10; e.wr = rd; e.wr_chk = 1'b1; e.rw = (rd != 0) ? 1 : 0;
      end
      6'h08: begin
        e.end_off = 3; e.imm = 1'b1; e.wr = e.rt; e.wr_chk = 1'b1; e.rw = (e.rt != 0) ? 1 : 0;
      end
      6'h23: begin
        e.imm = 1'b1;
        if (w < 0) begin
          e.ill = 1'b1; e.end_off = 3 + TO; e.mr = TO;
        end else begin
          e.end_off = 4 + w; e.mr = w + 1; e.wr = e.rt; e.wr_chk = 1'b1;
          e.rw = (e.rt != 0) ? 1 : 0; e.m2r = 1'b1;
        end
      end
      6'h2B: begin
        e.imm = 1'b1;
        if (w < 0) begin
          e.ill = 1'b1; e.end_off = 3 + TO; e.mw = TO;
        end else begin
          e.end_off = 3 + w; e.mw = w + 1;
        end
      end
      6'h04: begin
        e.end_off = 2; e.aluop = 2'b01; e.bt = z;
      end
      default: begin
        e.ill = 1'b1; e.end_off = 1;
      end
    endcase
    return e;
  endfunction

  // Monitor: accumulates observations per in-flight instruction and scores them at retire/abort.
  int         ncyc = 0;
  int         acc = 0;
  int         off;
  int         rre_c, mr_c, mw_c, rw_c;
  int         model_cnt = 0;
  logic [4:0] o_rs, o_rt;
  logic [1:0] o_aluop;
  logic       o_imm;
  bit         infl = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    if (reset) begin
      infl      = 1'b0;
      model_cnt = 0;
    end else begin
      if (!infl) begin
        check("idle_outs", {instr_ready, busy, ir_write, reg_read_en, reg_write,
                            mem_read, mem_write, pc_write, illegal}, 9'b100000000);
      end else begin
        off = ncyc - acc;
        if (ir_write) check("ir_write_off", off, 1);
        if (reg_read_en) begin
          rre_c++;
          o_rs = rs_addr;
          o_rt = rt_addr;
        end
        if (off == 2) begin
          o_aluop = aluop;
          o_imm   = alu_src_imm;
        end
        if (mem_read)  mr_c++;
        if (mem_write) mw_c++;
        if (reg_write) rw_c++;
        if (pc_write || illegal) begin
          if (sb_q.size() == 0) begin
            check("unexpected_evt", {pc_write, illegal}, 0);
          end else begin
            ev = sb_q.pop_front();
            check("latency", off, ev.end_off);
            check("evt_kind", {pc_write, illegal}, ev.ill ? 2'b01 : 2'b10);
            check("branch_taken", branch_taken, ev.bt);
            check("rd_en_cycles", rre_c, 1);
            check("rs_addr", o_rs, ev.rs);
            check("rt_addr", o_rt, ev.rt);
            if (ev.end_off >= 2) begin
              check("aluop", o_aluop, ev.aluop);
              check("alu_src_imm", o_imm, ev.imm);
            end
            check("mem_read_cycles", mr_c, ev.mr);
            check("mem_write_cycles", mw_c, ev.mw);
            check("reg_write_cnt", rw_c, ev.rw);
            if (ev.wr_chk) check("wr_addr", wr_addr, ev.wr);
            check("mem_to_reg", mem_to_reg, ev.m2r);
            check("retired_count", retired_count, model_cnt);
            if (!ev.ill) model_cnt = (model_cnt + 1) % 4;
          end
          infl = 1'b0;
        end
      end
      if (instr_valid && instr_ready) begin
        infl = 1'b1; acc = ncyc;
        rre_c = 0; mr_c = 0; mw_c = 0; rw_c = 0;
        o_rs = 5'd0; o_rt = 5'd0; o_aluop = 2'b00; o_imm = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    int g = 0;
    while (!instr_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (!instr_ready) check("ready_wait", instr_ready, 1);
  endtask

  // Drive one instruction; memory answers after w wait cycles (w < 0: never).
  task automatic issue(input logic [31:0] ins, input logic z, input int w);
    wait_ready();
    sb_q.push_back(model(ins, z, w));
    instruction = ins;
    alu_zero    = z;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (w >= 0 && (ins[31:26] == 6'h23 || ins[31:26] == 6'h2B)) begin
      repeat (2 + w) @(posedge clk);
      #1;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((sb_q.size() != 0 || !instr_ready) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instruction = 32'd0;
    alu_zero    = 1'b0;
    mem_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {instr_ready, busy, ir_write, reg_read_en, reg_write, mem_to_reg,
                       alu_src_imm, mem_read, mem_write, pc_write, branch_taken, illegal},
          12'b100000000000);
    check("rst_aluop", aluop, 0);
    check("rst_addrs", {rs_addr, rt_addr, wr_addr}, 0);
    check("rst_count", retired_count, 0);
    reset = 1'b0;

    issue(32'h02324020, 1'b0, 0);   // add $t0,$s1,$s2
    issue(32'h8D300004, 1'b0, 2);   // lw $s0,4($t1), two wait cycles
    issue(32'h12110010, 1'b1, 0);   // beq $s0,$s1 taken
    issue(32'h12110010, 1'b0, 0);   // beq $s0,$s1 not taken
    issue(32'hFC000000, 1'b0, 0);   // opcode 0x3F
    issue(32'hAD300008, 1'b0, -1);  // sw, memory never ready
    issue(32'hAD300008, 1'b0, 0);   // sw, ready on MEM entry
    issue(32'h8D300004, 1'b0, 0);   // lw, ready on MEM entry
    drain();

    // Reset while a load waits in MEM: the instruction is dropped.
    wait_ready();
    instruction = 32'h8D300004;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_mem_read", mem_read, 1);
    check("pre_rst_count", retired_count, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("post_rst_ctrl", {busy, instr_ready, mem_read, reg_write, pc_write}, 5'b01000);
    check("post_rst_count", retired_count, 0);

    issue(32'h20000005, 1'b0, 0);   // addi $zero,$zero,5: retires without a write
    issue(32'h02324020, 1'b0, 0);
    issue(32'h12110010, 1'b1, 0);
    issue(32'h02324020, 1'b0, 0);   // fourth retire wraps the 2-bit counter
    drain();
    @(posedge clk); #1;
    check("wrap_count", retired_count, 0);
    check("final_count", retired_count, model_cnt);
    check("sb_left", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
